reg_file_mp: RTL

Parametrised multi-port register file: one write port, two independent registered read ports, write-to-read bypass, and a hardware clear sequencer. It is the general-purpose register storage for the datapath. It replaces the fixed 8×16 single-port, tri-stated register file. Outputs are point-to-point buses, never high-Z.

---
 rtl/reg_file_mp_pkg.sv | 13 +
 rtl/reg_file_mp_if.sv | 39 +++
 rtl/reg_file_read_port.sv | 66 ++++++
 rtl/reg_file_mp.sv | 114 +++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared types and default geometry for the multi-port register file.
// Instantiating blocks pick up DEF_WIDTH/DEF_DEPTH from here.
package reg_file_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: write port, two read ports, clear control.
// master drives requests, slave is the register file.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              writeEn;
  logic [ADDR_W-1:0] writeAddr;
  logic [WIDTH-1:0]  writeData;
  logic              readEnA;
  logic [ADDR_W-1:0] readAddrA;
  logic [WIDTH-1:0]  outA;
  logic              validA;
  logic              readEnB;
  logic [ADDR_W-1:0] readAddrB;
  logic [WIDTH-1:0]  outB;
  logic              validB;
  logic              clearReq;
  logic              busy;

  modport master (
    output writeEn, writeAddr, writeData,
    output readEnA, readAddrA, readEnB, readAddrB,
    output clearReq,
    input  outA, validA, outB, validB, busy
  );

  modport slave (
    input  writeEn, writeAddr, writeData,
    input  readEnA, readAddrA, readEnB, readAddrB,
    input  clearReq,
    output outA, validA, outB, validB, busy
  );

endinterface

// File: rtl/reg_file_read_port.sv
// One registered read port: range check, write-first bypass, out/valid regs.
// Out-of-range addresses read as zero but still flag valid.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_i,
  input  logic [ADDR_W-1:0]           addr_i,
  input  logic [DEPTH-1:0][WIDTH-1:0] mem_i,
  input  logic                        wr_en_i,
  input  logic [ADDR_W-1:0]           wr_addr_i,
  input  logic [WIDTH-1:0]            wr_data_i,
  output logic [WIDTH-1:0]            data_o,
  output logic                        valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] rd;
  logic             hit;

  always_comb begin
    hit = 1'b0;
    rd  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_i == ADDR_W'(i)) begin
        hit = 1'b1;
        rd  = mem_i[i];
      end
    end
  end

  // wr_en_i is only ever high for an accepted in-range write
  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (en_i) begin
      valid_d = 1'b1;
      if (!hit)
        data_d = '0;
      else if (wr_en_i && (wr_addr_i == addr_i))
        data_d = wr_data_i;
      else
        data_d = rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: storage, write logic and the clear sweeper.
// Reads go through two reg_file_read_port instances.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic          clk,
  input logic          rst,
  reg_file_mp_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  state_e                      state_q;
  logic [ADDR_W-1:0]           idx_q;
  logic                        busy_q;

  logic idle;
  logic wr_inrange;
  logic wr_ok;

  assign idle = (state_q == ST_IDLE);

  always_comb begin
    wr_inrange = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (bus.writeAddr == ADDR_W'(i))
        wr_inrange = 1'b1;
  end

  // A clear request in the same cycle wins over the write
  assign wr_ok = idle && bus.writeEn && !bus.clearReq && wr_inrange;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (bus.clearReq) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          idx_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!idle && (idx_q == ADDR_W'(i)))
          mem_q[i] <= '0;
        else if (wr_ok && (bus.writeAddr == ADDR_W'(i)))
          mem_q[i] <= bus.writeData;
      end
    end
  end

  reg_file_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_rd_a (
    .clk       (clk),
    .rst       (rst),
    .en_i      (bus.readEnA && idle),
    .addr_i    (bus.readAddrA),
    .mem_i     (mem_q),
    .wr_en_i   (wr_ok),
    .wr_addr_i (bus.writeAddr),
    .wr_data_i (bus.writeData),
    .data_o    (bus.outA),
    .valid_o   (bus.validA)
  );

  reg_file_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_rd_b (
    .clk       (clk),
    .rst       (rst),
    .en_i      (bus.readEnB && idle),
    .addr_i    (bus.readAddrB),
    .mem_i     (mem_q),
    .wr_en_i   (wr_ok),
    .wr_addr_i (bus.writeAddr),
    .wr_data_i (bus.writeData),
    .data_o    (bus.outB),
    .valid_o   (bus.validB)
  );

  assign bus.busy = busy_q;

endmodule
